// File: rtl/fxp_add_sat.sv
// Pipelined signed fixed-point adder/subtractor with selectable rounding,
// output saturation and a sticky count of clipped results.
module fxp_add_sat #(
  parameter int unsigned A_W       = 8,
  parameter int unsigned A_FRAC    = 4,
  parameter int unsigned B_W       = 6,
  parameter int unsigned B_FRAC    = 3,
  parameter int unsigned C_W       = 5,
  parameter int unsigned C_FRAC    = 1,
  parameter int unsigned SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic                 in_sub,
  input  logic [1:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [C_W-1:0]       out_c,
  output logic                 out_sat,
  input  logic                 clr_cnt,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int unsigned A_INT = A_W - A_FRAC;
  localparam int unsigned B_INT = B_W - B_FRAC;
  localparam int unsigned F     = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
  localparam int unsigned I     = (A_INT > B_INT) ? A_INT : B_INT;
  // Exact sum width: one guard bit above the widest integer part
  localparam int unsigned S_W   = I + F + 1;
  localparam int unsigned A_SH  = F - A_FRAC;
  localparam int unsigned B_SH  = F - B_FRAC;
  localparam int unsigned D     = (F > C_FRAC) ? F - C_FRAC : 0;
  localparam int unsigned UP    = (C_FRAC > F) ? C_FRAC - F : 0;
  // Working width: room for the rounding increment or the left shift,
  // and always wider than the result so the clamp compare is meaningful
  localparam int unsigned X_W0  = S_W + 1 + UP;
  localparam int unsigned X_W   = (X_W0 > C_W + 1) ? X_W0 : C_W + 1;

  localparam logic signed [X_W-1:0] C_MAX = {{(X_W-C_W+1){1'b0}}, {(C_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] C_MIN = {{(X_W-C_W+1){1'b1}}, {(C_W-1){1'b0}}};

  logic                  s1_valid;
  logic                  s2_valid;
  logic signed [S_W-1:0] s1_sum;
  logic [1:0]            s1_rnd;
  logic                  s2_load;

  logic signed [S_W-1:0] a_al;
  logic signed [S_W-1:0] b_al;
  logic signed [S_W-1:0] sum_c;
  logic signed [X_W-1:0] x_ext;
  logic signed [X_W-1:0] x_res;
  logic [C_W-1:0]        c_c;
  logic                  sat_c;

  // Handshake: s2 drains into the consumer, s1 follows s2
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  // Stage 1 datapath: align both operands to F fractional bits and combine
  always_comb begin
    a_al  = S_W'($signed(in_a)) <<< A_SH;
    b_al  = S_W'($signed(in_b)) <<< B_SH;
    sum_c = in_sub ? (a_al - b_al) : (a_al + b_al);
  end

  assign x_ext = X_W'(s1_sum);

  generate
    if (D > 0) begin : g_round
      localparam logic [X_W-1:0] HALF = X_W'(1) << (D - 1);
      logic signed [X_W-1:0] x_up_sum;
      logic signed [X_W-1:0] x_flr;
      logic signed [X_W-1:0] x_up;
      logic                  tie;

      // Drop D fraction bits: floor, half-up, or half-even on exact ties
      always_comb begin
        x_up_sum = x_ext + $signed(HALF);
        x_flr    = x_ext >>> D;
        x_up     = x_up_sum >>> D;
        tie      = (x_ext[D-1:0] == HALF[D-1:0]);
        case (s1_rnd)
          2'b01:   x_res = x_up;
          2'b10:   x_res = (tie && x_up[0]) ? x_flr : x_up;
          default: x_res = x_flr;
        endcase
      end
    end else begin : g_shift
      // Result has at least as many fraction bits: exact left shift
      always_comb begin
        x_res = x_ext <<< UP;
      end
    end
  endgenerate

  // Clamp to the representable result range and flag any clipping
  always_comb begin
    c_c   = x_res[C_W-1:0];
    sat_c = 1'b0;
    if (x_res > C_MAX) begin
      c_c   = C_MAX[C_W-1:0];
      sat_c = 1'b1;
    end else if (x_res < C_MIN) begin
      c_c   = C_MIN[C_W-1:0];
      sat_c = 1'b1;
    end
  end

  // Pipeline valid bits and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_c    <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        out_c   <= c_c;
        out_sat <= sat_c;
      end
    end
  end

  // Stage 1 payload, loaded only on an accepted beat
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      s1_sum <= sum_c;
      s1_rnd <= rnd_mode;
    end
  end

  // Sticky clip counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      sat_cnt <= '0;
    end else if (s2_valid && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_add_sat.sv
// Self-checking bench for fxp_add_sat with default parameters.
module tb_fxp_add_sat;

  localparam int unsigned A_W = 8, A_FRAC = 4, B_W = 6, B_FRAC = 3;
  localparam int unsigned C_W = 5, C_FRAC = 1, SAT_CNT_W = 16;
  localparam int unsigned NV = 18;

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           sub;
    logic [1:0]     rnd;
    logic [C_W-1:0] c;
    logic           sat;
  } vec_t;

  typedef struct {
    logic [C_W-1:0] c;
    logic           sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [A_W-1:0]       in_a = '0;
  logic [B_W-1:0]       in_b = '0;
  logic                 in_sub = 1'b0;
  logic [1:0]           rnd_mode = 2'b00;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [C_W-1:0]       out_c;
  logic                 out_sat;
  logic                 clr_cnt = 1'b0;
  logic [SAT_CNT_W-1:0] sat_cnt;

  int   checks = 0;
  int   errors = 0;
  logic rdy_val = 1'b1;
  logic rdy_rand = 1'b0;
  exp_t sbq[$];
  logic prev_stall = 1'b0;
  logic [6:0] prev_out = '0;

  fxp_add_sat #(
    .A_W(A_W), .A_FRAC(A_FRAC), .B_W(B_W), .B_FRAC(B_FRAC),
    .C_W(C_W), .C_FRAC(C_FRAC), .SAT_CNT_W(SAT_CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_sat(out_sat),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Real-valued reference: exact value, rounded in result LSBs, clipped to [-8, 7.5]
  function automatic exp_t model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                 input logic s, input logic [1:0] r);
    real  va, vb, v, f;
    int   q;
    exp_t e;
    va = $itor($signed(a)) / 16.0;
    vb = $itor($signed(b)) / 8.0;
    v  = s ? (va - vb) : (va + vb);
    v  = v * 2.0;
    f  = $floor(v);
    case (r)
      2'b01: f = $floor(v + 0.5);
      2'b10: begin
        if (v - f > 0.5) f = f + 1.0;
        else if ((v - f == 0.5) && ($rtoi(f) % 2 != 0)) f = f + 1.0;
      end
      default: ;
    endcase
    q = $rtoi(f);
    e.sat = 1'b0;
    if (q > 15) begin q = 15; e.sat = 1'b1; end
    if (q < -16) begin q = -16; e.sat = 1'b1; end
    e.c = C_W'(q);
    return e;
  endfunction

  // Output monitor: scoreboard compare on transfer, stability check while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 32'({out_valid, out_c, out_sat}), 32'(prev_out));
      if (out_valid && out_ready) begin : pop
        exp_t e;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got c=0x%0h sat=%0b with nothing pending", out_c, out_sat);
        end else begin
          e = sbq.pop_front();
          chk("result", 32'({out_c, out_sat}), 32'({e.c, e.sat}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_c, out_sat};
    end
  end

  // Consumer: fixed or pseudo-random out_ready, updated just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat (called just after a rising edge); returns after it transfers
  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      input logic s, input logic [1:0] r, input exp_t e);
    int n;
    n = 0;
    in_a = a; in_b = b; in_sub = s; rnd_mode = r; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) break;
    end
    if (in_ready) sbq.push_back(e);
    else chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      cyc(1);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[NV];
    exp_t e;
    int   nsat;
    logic [B_W-1:0] bl[3];

    vecs[0]  = '{8'h18, 6'h04, 1'b0, 2'b00, 5'h04, 1'b0};
    vecs[1]  = '{8'h70, 6'h08, 1'b0, 2'b00, 5'h0F, 1'b1};
    vecs[2]  = '{8'h80, 6'h38, 1'b0, 2'b00, 5'h10, 1'b1};
    vecs[3]  = '{8'h04, 6'h00, 1'b0, 2'b00, 5'h00, 1'b0};
    vecs[4]  = '{8'h04, 6'h00, 1'b0, 2'b01, 5'h01, 1'b0};
    vecs[5]  = '{8'h04, 6'h00, 1'b0, 2'b10, 5'h00, 1'b0};
    vecs[6]  = '{8'h0C, 6'h00, 1'b0, 2'b00, 5'h01, 1'b0};
    vecs[7]  = '{8'h0C, 6'h00, 1'b0, 2'b01, 5'h02, 1'b0};
    vecs[8]  = '{8'h0C, 6'h00, 1'b0, 2'b10, 5'h02, 1'b0};
    vecs[9]  = '{8'hFC, 6'h00, 1'b0, 2'b00, 5'h1F, 1'b0};
    vecs[10] = '{8'hFC, 6'h00, 1'b0, 2'b01, 5'h00, 1'b0};
    vecs[11] = '{8'hFC, 6'h00, 1'b0, 2'b10, 5'h00, 1'b0};
    vecs[12] = '{8'h10, 6'h20, 1'b1, 2'b00, 5'h0A, 1'b0};
    vecs[13] = '{8'h70, 6'h20, 1'b1, 2'b00, 5'h0F, 1'b1};
    vecs[14] = '{8'h0C, 6'h00, 1'b0, 2'b11, 5'h01, 1'b0};
    vecs[15] = '{8'h14, 6'h00, 1'b0, 2'b10, 5'h02, 1'b0};
    vecs[16] = '{8'h70, 6'h04, 1'b0, 2'b00, 5'h0F, 1'b0};
    vecs[17] = '{8'h00, 6'h20, 1'b1, 2'b00, 5'h08, 1'b0};

    // Reset state
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_c", 32'(out_c), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    cyc(1);

    // Two-cycle latency of the first beat
    in_a = 8'h18; in_b = 6'h04; in_sub = 1'b0; rnd_mode = 2'b00; in_valid = 1'b1;
    e.c = 5'h04; e.sat = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    chk("lat_cycle0", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    cyc(1);
    drain();

    // Directed table, back to back
    nsat = 0;
    for (int i = 0; i < int'(NV); i++) begin
      e.c = vecs[i].c; e.sat = vecs[i].sat;
      if (vecs[i].sat) nsat++;
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].rnd, e);
    end
    drain();
    @(negedge clk);
    chk("sat_cnt_table", 32'(sat_cnt), 32'(nsat));
    cyc(1);
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("sat_cnt_clr", 32'(sat_cnt), 32'd0);
    cyc(1);

    // Clipped result transferring in the clear cycle is not counted
    rdy_val = 1'b0;
    e.c = 5'h0F; e.sat = 1'b1;
    send(8'h70, 6'h08, 1'b0, 2'b00, e);
    cyc(3);
    clr_cnt = 1'b1;
    rdy_val = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_vs_inc", 32'(sat_cnt), 32'd0);
    cyc(1);
    drain();

    // Fill under backpressure: two beats held, then in_ready drops
    rdy_val = 1'b0;
    send(8'h10, 6'h08, 1'b0, 2'b00, model(8'h10, 6'h08, 1'b0, 2'b00));
    send(8'h20, 6'h30, 1'b1, 2'b01, model(8'h20, 6'h30, 1'b1, 2'b01));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    cyc(4);

    // Ten incrementing beats with a random consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(A_W'(i * 13), B_W'(i * 5), 1'(i), 2'(i),
           model(A_W'(i * 13), B_W'(i * 5), 1'(i), 2'(i)));
    end
    drain();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    cyc(2);

    // Every a/b/sub pair, rounding mode rotating across the sweep
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 64; b++)
        for (int s = 0; s < 2; s++)
          send(A_W'(a), B_W'(b), 1'(s), 2'(a + b + s),
               model(A_W'(a), B_W'(b), 1'(s), 2'(a + b + s)));
    // Every a with all four modes on a few b values
    bl[0] = 6'h00; bl[1] = 6'h20; bl[2] = 6'h1F;
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 3; j++)
        for (int s = 0; s < 2; s++)
          for (int r = 0; r < 4; r++)
            send(A_W'(a), bl[j], 1'(s), 2'(r), model(A_W'(a), bl[j], 1'(s), 2'(r)));
    drain();
    cyc(1);
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;

    // Reset with the pipeline full and a nonzero count
    e.c = 5'h10; e.sat = 1'b1;
    send(8'h80, 6'h38, 1'b0, 2'b00, e);
    drain();
    @(negedge clk);
    chk("sat_cnt_one", 32'(sat_cnt), 32'd1);
    cyc(1);
    rdy_val = 1'b0;
    send(8'h18, 6'h04, 1'b0, 2'b00, model(8'h18, 6'h04, 1'b0, 2'b00));
    send(8'h0C, 6'h00, 1'b0, 2'b01, model(8'h0C, 6'h00, 1'b0, 2'b01));
    rst = 1'b1;
    rdy_val = 1'b1;
    cyc(1);
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    cyc(1);
    send(8'h10, 6'h20, 1'b1, 2'b00, model(8'h10, 6'h20, 1'b1, 2'b00));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
